fp_unpack: RTL and testbench

- Operand-side counterpart of the FPU result packer: it takes a raw IEEE-754 single-precision word and splits it into sign, extended exponent, normalized 24-bit mantissa and a 2-bit class flag.
- The class flag uses the same encoding the packer consumes on its flag input.
- Subnormal inputs are normalized by an iterative one-bit-per-cycle shifter, so the datapath downstream only ever sees m[23]=1 for nonzero finite values.
- Sits between the operand registers and the FPU arithmetic core, with a valid/ready handshake on both sides.

---
 rtl/fp_unpack.sv | 142 ++++++++++++++
 tb/tb_fp_unpack.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_unpack.sv
// ============================================================================
// Module  : fp_unpack
// Purpose : Splits an IEEE-754 single word into sign, extended exponent,
//           normalized mantissa and class flag; subnormals shift 1 bit/cycle.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_unpack #(
    parameter int EW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   a,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          s,
    output logic [EW-1:0] e,
    output logic [23:0]   m,
    output logic [1:0]    flag,
    output logic          sub,
    output logic [4:0]    shamt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] EXP_MAX    = 8'hFF;
    localparam logic [1:0] FLAG_FIN   = 2'b00;
    localparam logic [1:0] FLAG_ZERO  = 2'b01;
    localparam logic [1:0] FLAG_INF   = 2'b10;
    localparam logic [1:0] FLAG_NAN   = 2'b11;

    state_t        state_q, state_d;
    logic          s_q, s_d;
    logic [EW-1:0] e_q, e_d;
    logic [23:0]   m_q, m_d;
    logic [1:0]    flag_q, flag_d;
    logic          sub_q, sub_d;
    logic [4:0]    shamt_q, shamt_d;

    logic [7:0]    exp_w;
    logic [22:0]   frac_w;
    logic [EW-1:0] exp_ext_w;

    assign exp_w     = a[30:23];
    assign frac_w    = a[22:0];
    assign exp_ext_w = {{(EW-8){1'b0}}, exp_w};

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        e_d     = e_q;
        m_d     = m_q;
        flag_d  = flag_q;
        sub_d   = sub_q;
        shamt_d = shamt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    s_d     = a[31];
                    sub_d   = 1'b0;
                    shamt_d = 5'd0;
                    state_d = DONE;
                    if (exp_w == EXP_MAX) begin
                        e_d    = exp_ext_w;
                        flag_d = (frac_w != 23'd0) ? FLAG_NAN : FLAG_INF;
                        m_d    = {1'b0, frac_w};
                    end else if (exp_w == 8'd0) begin
                        if (frac_w == 23'd0) begin
                            e_d    = '0;
                            flag_d = FLAG_ZERO;
                            m_d    = 24'd0;
                        end else begin
                            // Subnormal: start at the minimum normal exponent and shift up.
                            e_d     = EW'(1);
                            flag_d  = FLAG_FIN;
                            m_d     = {1'b0, frac_w};
                            sub_d   = 1'b1;
                            state_d = NORM;
                        end
                    end else begin
                        e_d    = exp_ext_w;
                        flag_d = FLAG_FIN;
                        m_d    = {1'b1, frac_w};
                    end
                end
            end
            NORM: begin
                m_d     = {m_q[22:0], 1'b0};
                e_d     = e_q - EW'(1);
                shamt_d = shamt_q + 5'd1;
                if (m_q[22]) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            s_q     <= 1'b0;
            e_q     <= '0;
            m_q     <= 24'd0;
            flag_q  <= 2'b00;
            sub_q   <= 1'b0;
            shamt_q <= 5'd0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            e_q     <= e_d;
            m_q     <= m_d;
            flag_q  <= flag_d;
            sub_q   <= sub_d;
            shamt_q <= shamt_d;
        end
    end

    assign in_ready  = rst_n && (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign s         = s_q;
    assign e         = e_q;
    assign m         = m_q;
    assign flag      = flag_q;
    assign sub       = sub_q;
    assign shamt     = shamt_q;

endmodule

`default_nettype wire

// File: tb/tb_fp_unpack.sv
// ============================================================================
// Module  : tb_fp_unpack
// Purpose : Directed-vector bench for fp_unpack with an arithmetic reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp_unpack;

    localparam int EW = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   a_i;
    logic          out_valid;
    logic          out_ready;
    logic          s;
    logic [EW-1:0] e;
    logic [23:0]   m;
    logic [1:0]    flag;
    logic          sub;
    logic [4:0]    shamt;

    fp_unpack #(.EW(EW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .e         (e),
        .m         (m),
        .flag      (flag),
        .sub       (sub),
        .shamt     (shamt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic          s;
        logic [EW-1:0] e;
        logic [23:0]   m;
        logic [1:0]    flag;
        logic          sub;
        logic [4:0]    shamt;
        int            lat;
        int            acc;
    } res_t;

    res_t q[$];
    bit   hs_prev = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s at cycle %0d: actual=%h required=%h", nm, cyc, act, req);
        end
    endtask

    // Reference: classify numerically; subnormals are doubled until the hidden bit appears.
    function automatic res_t model(input logic [31:0] x);
        res_t   r;
        int     expo;
        int     frac;
        int     k;
        longint v;
        expo    = int'(x[30:23]);
        frac    = int'(x[22:0]);
        r.s     = x[31];
        r.sub   = 1'b0;
        r.shamt = 5'd0;
        r.lat   = 1;
        r.acc   = 0;
        if (expo == 255) begin
            r.e    = EW'(255);
            r.flag = (frac != 0) ? 2'b11 : 2'b10;
            r.m    = 24'(frac);
        end else if (expo == 0 && frac == 0) begin
            r.e    = '0;
            r.flag = 2'b01;
            r.m    = 24'd0;
        end else if (expo != 0) begin
            r.e    = EW'(expo);
            r.flag = 2'b00;
            r.m    = 24'(frac + 2**23);
        end else begin
            k = 0;
            v = longint'(frac);
            while (v < 2**23) begin
                v = v * 2;
                k++;
            end
            r.e     = EW'(1 - k);
            r.flag  = 2'b00;
            r.sub   = 1'b1;
            r.m     = 24'(v);
            r.shamt = 5'(k);
            r.lat   = 1 + k;
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            hs_prev = 1'b0;
        end else begin
            if (hs_prev) begin
                chk("post_hs_valid", {31'd0, out_valid}, 32'd0);
                chk("post_hs_ready", {31'd0, in_ready}, 32'd1);
                hs_prev = 1'b0;
            end
            if (q.size() > 0) begin
                if (cyc == q[0].acc + q[0].lat)
                    chk("latency", {31'd0, out_valid}, 32'd1);
                if (out_valid) begin
                    chk("not_early", {31'd0, (cyc >= q[0].acc + q[0].lat)}, 32'd1);
                    chk("s", {31'd0, s}, {31'd0, q[0].s});
                    chk("e", {22'd0, e}, {22'd0, q[0].e});
                    chk("m", {8'd0, m}, {8'd0, q[0].m});
                    chk("flag", {30'd0, flag}, {30'd0, q[0].flag});
                    chk("sub", {31'd0, sub}, {31'd0, q[0].sub});
                    chk("shamt", {27'd0, shamt}, {27'd0, q[0].shamt});
                    chk("busy_ready", {31'd0, in_ready}, 32'd0);
                    if (out_ready) begin
                        void'(q.pop_front());
                        hs_prev = 1'b1;
                    end
                end
            end else if (out_valid) begin
                chk("unexpected_valid", {31'd0, out_valid}, 32'd0);
            end
            if (in_valid && in_ready) begin
                res_t r;
                r     = model(a_i);
                r.acc = cyc;
                q.push_back(r);
            end
        end
    end

    task automatic send(input logic [31:0] x);
        bit got;
        got = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        a_i      = x;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
        end
        chk("accept_timeout", {31'd0, got}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 100; i++) begin
            if (q.size() == 0) break;
            @(posedge clk);
        end
        chk("drain", q.size(), 32'd0);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        chk({tag, "_s"}, {31'd0, s}, 32'd0);
        chk({tag, "_e"}, {22'd0, e}, 32'd0);
        chk({tag, "_m"}, {8'd0, m}, 32'd0);
        chk({tag, "_flag"}, {30'd0, flag}, 32'd0);
        chk({tag, "_sub"}, {31'd0, sub}, 32'd0);
        chk({tag, "_shamt"}, {27'd0, shamt}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        res_t r;
        logic [31:0] vec [12];
        bit seen_v;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a_i       = 32'd0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");

        // Hand-computed pins on the reference model.
        r = model(32'h3F800000);
        chk("pin_1p0_e", {22'd0, r.e}, 32'd127);
        chk("pin_1p0_m", {8'd0, r.m}, 32'h800000);
        r = model(32'h00000001);
        chk("pin_min_e", {22'd0, r.e}, 32'h3EA);
        chk("pin_min_shamt", {27'd0, r.shamt}, 32'd23);
        chk("pin_min_lat", r.lat, 32'd24);
        r = model(32'h80400000);
        chk("pin_half_e", {22'd0, r.e}, 32'd0);
        chk("pin_half_lat", r.lat, 32'd2);
        r = model(32'h7FC00001);
        chk("pin_nan_m", {8'd0, r.m}, 32'h400001);
        chk("pin_nan_flag", {30'd0, r.flag}, 32'd3);

        rst_n = 1'b1;

        vec = '{32'h3F800000, 32'h00000001, 32'h80400000, 32'h7F800000,
                32'h7FC00001, 32'h80000000, 32'h00400000, 32'h807FFFFF,
                32'h00000100, 32'h7F7FFFFF, 32'h00800000, 32'hC0490FDB};
        foreach (vec[i]) begin
            send(vec[i]);
            wait_done();
        end

        // Backpressure: consumer stalls for five cycles after the result appears.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(32'h12345678);
        seen_v = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen_v = 1'b1;
                break;
            end
        end
        chk("bp_valid", {31'd0, seen_v}, 32'd1);
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_done();
        send(32'h3F800000);
        wait_done();

        // Reset in the middle of a long normalization.
        send(32'h00000001);
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_reset_state("midnorm");
        rst_n = 1'b1;
        r = model(32'h40000000);
        chk("pin_two_e", {22'd0, r.e}, 32'd128);
        send(32'h40000000);
        wait_done();

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
